// File: rtl/aes_pkg.sv
// Shared constants and state type for the AES round-key sequencer.
package aes_pkg;

  localparam int unsigned AES_KEY_LEN  = 128;
  localparam int unsigned AES_WORD_LEN = 32;
  localparam int unsigned AES_NR       = 10;
  localparam int unsigned AES_TIMEOUT  = 15;
  localparam int unsigned RIDX_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } ks_state_t;

endpackage

// File: rtl/key_schedule_ctrl_round_key_rf.sv
// (NR+1) x KEY_LEN round-key storage: one write port, one registered read port.
module round_key_rf
  import aes_pkg::*;
#(
  parameter int unsigned KEY_LEN = AES_KEY_LEN,
  parameter int unsigned NR      = AES_NR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [RIDX_W-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0] wr_data,
  input  logic [RIDX_W-1:0]  rd_idx,
  output logic [KEY_LEN-1:0] rd_data
);

  localparam logic [RIDX_W-1:0] LAST_SLOT = RIDX_W'(NR);

  logic [KEY_LEN-1:0] mem [NR+1];

  // Slot storage; writes to indices past the last slot are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i <= NR; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wr_idx <= LAST_SLOT)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Registered read; out-of-range slots read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= (rd_idx <= LAST_SLOT) ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequences GenSubKey through NR rounds, chaining each round key into the next
// request, and stores every round key for the cipher datapath.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned KEY_LEN  = AES_KEY_LEN,
  parameter int unsigned WORD_LEN = AES_WORD_LEN,
  parameter int unsigned NR       = AES_NR,
  parameter int unsigned TIMEOUT  = AES_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEY_LEN-1:0] key_in,
  input  logic               key_valid,
  output logic               key_ready,
  output logic [RIDX_W-1:0]  gsk_round_n,
  output logic [KEY_LEN-1:0] gsk_data,
  output logic               gsk_valid_in,
  input  logic [KEY_LEN-1:0] gsk_data_in,
  input  logic               gsk_valid_out,
  input  logic [RIDX_W-1:0]  rd_round,
  output logic [KEY_LEN-1:0] rd_key,
  output logic               keys_ready,
  output logic               busy,
  output logic               err
);

  localparam int unsigned       TMR_W      = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LIMIT  = TMR_W'(TIMEOUT);
  localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(NR - 1);

  if (KEY_LEN != 4 * WORD_LEN) begin : g_len_check
    $error("KEY_LEN must be exactly four WORD_LEN words");
  end

  ks_state_t          state_q, state_d;
  logic [RIDX_W-1:0]  round_q, round_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [KEY_LEN-1:0] chain_q, chain_d;
  logic               rf_we;
  logic [RIDX_W-1:0]  rf_wr_idx;
  logic [KEY_LEN-1:0] rf_wr_data;

  // chain_q mirrors slot[round] so the request data needs no second RF read port.
  assign gsk_data     = chain_q;
  assign gsk_round_n  = round_q;
  assign gsk_valid_in = (state_q == ST_ISSUE);
  assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign key_ready    = !busy;
  assign keys_ready   = (state_q == ST_DONE);
  assign err          = (state_q == ST_ERR);

  // State, round, timeout and chain registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      timer_q <= '0;
      chain_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      timer_q <= timer_d;
      chain_q <= chain_d;
    end
  end

  // Next-state logic and slot write requests.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    timer_d    = timer_q;
    chain_d    = chain_q;
    rf_we      = 1'b0;
    rf_wr_idx  = round_q + 1'b1;
    rf_wr_data = gsk_data_in;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (key_valid) begin
          rf_we      = 1'b1;
          rf_wr_idx  = '0;
          rf_wr_data = key_in;
          chain_d    = key_in;
          round_d    = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A response on the timeout cycle still counts.
        if (gsk_valid_out) begin
          rf_we   = 1'b1;
          chain_d = gsk_data_in;
          if (round_q == LAST_ROUND) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end else if (timer_q == TMR_LIMIT) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  round_key_rf #(
    .KEY_LEN(KEY_LEN),
    .NR     (NR)
  ) u_rf (
    .clk    (clk),
    .rst    (reset),
    .we     (rf_we),
    .wr_idx (rf_wr_idx),
    .wr_data(rf_wr_data),
    .rd_idx (rd_round),
    .rd_data(rd_key)
  );

endmodule
